// File: rtl/uart_pixel_framer.sv
// Byte-stream to pixel framer: hunts for SOF, packs R,G,B byte triples into pixel words.
// Optional trailing XOR checksum byte per frame when UART_PIXEL_FRAMER_CHECKSUM_EN is defined.
module uart_pixel_framer #(
  parameter int          PANEL_ROWS     = 64,
  parameter int          PANEL_COLS     = 64,
  parameter int          COLOR_DEPTH    = 4,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  input  logic [7:0]                 rx_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_sof,
  output logic [3*COLOR_DEPTH-1:0]   pix_rgb,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [7:0]                 err_count
);

  localparam int CD    = COLOR_DEPTH;
  localparam int NPIX  = PANEL_ROWS * PANEL_COLS;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAYLOAD = 2'd1, ST_CHECK = 2'd2} state_t;
  logic [7:0] xor_r;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAYLOAD = 2'd1} state_t;
`endif

  state_t                state_r;
  state_t                state_nxt_s;
  logic [1:0]            byte_idx_r;
  logic [CNT_W-1:0]      pix_cnt_r;
  logic                  sof_pend_r;
  logic [CD-1:0]         r_field_r;
  logic [CD-1:0]         g_field_r;
  logic [TMO_W-1:0]      tmo_cnt_r;
  logic                  ready_en_r;
  logic                  pix_valid_r;
  logic                  pix_sof_r;
  logic [3*CD-1:0]       pix_rgb_r;
  logic                  frame_done_r;
  logic                  frame_err_r;
  logic [7:0]            err_count_r;

  logic                  rx_ready_s;
  logic                  accept_s;
  logic                  load_s;
  logic                  done_evt_s;
  logic                  err_evt_s;
  logic                  tmo_hit_s;
  logic [CD-1:0]         chan_s;

  // ready_en_r keeps rx_ready low while reset is asserted
  assign rx_ready_s = ready_en_r & (~pix_valid_r | pix_ready);
  assign accept_s   = rx_valid & rx_ready_s;
  assign chan_s     = rx_data[7 -: CD];

  assign rx_ready   = rx_ready_s;
  assign pix_valid  = pix_valid_r;
  assign pix_sof    = pix_sof_r;
  assign pix_rgb    = pix_rgb_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;
  assign err_count  = err_count_r;

  // Next-state and frame event decode
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    done_evt_s  = 1'b0;
    err_evt_s   = 1'b0;
    tmo_hit_s   = (state_r != ST_IDLE) && rx_ready_s && !accept_s && (tmo_cnt_r == TMO_LAST);
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (rx_data == SOF_BYTE)) begin
          state_nxt_s = ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          if (byte_idx_r == 2'd2) begin
            load_s = 1'b1;
            if (pix_cnt_r == LAST_PIX) begin
`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
              state_nxt_s = ST_CHECK;
`else
              state_nxt_s = ST_IDLE;
              done_evt_s  = 1'b1;
`endif
            end else begin
              state_nxt_s = ST_PAYLOAD;
            end
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
          err_evt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          state_nxt_s = ST_IDLE;
          if (rx_data == xor_r) begin
            done_evt_s = 1'b1;
          end else begin
            err_evt_s  = 1'b1;
          end
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
          err_evt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ready_en_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ready_en_r <= 1'b1;
    end
  end

  // Frame datapath: byte position, pixel count, colour fields, idle timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_r <= 2'd0;
      pix_cnt_r  <= '0;
      sof_pend_r <= 1'b0;
      r_field_r  <= '0;
      g_field_r  <= '0;
      tmo_cnt_r  <= '0;
`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
      xor_r      <= 8'h00;
`endif
    end else begin
      if ((state_r == ST_IDLE) || accept_s) begin
        tmo_cnt_r <= '0;
      end else if (rx_ready_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      if ((state_r == ST_IDLE) && accept_s && (rx_data == SOF_BYTE)) begin
        byte_idx_r <= 2'd0;
        pix_cnt_r  <= '0;
        sof_pend_r <= 1'b1;
`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
        xor_r      <= 8'h00;
`endif
      end else if ((state_r == ST_PAYLOAD) && accept_s) begin
`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
        xor_r <= xor_r ^ rx_data;
`endif
        case (byte_idx_r)
          2'd0: begin
            r_field_r  <= chan_s;
            byte_idx_r <= 2'd1;
          end
          2'd1: begin
            g_field_r  <= chan_s;
            byte_idx_r <= 2'd2;
          end
          2'd2: begin
            byte_idx_r <= 2'd0;
            sof_pend_r <= 1'b0;
            pix_cnt_r  <= (pix_cnt_r == LAST_PIX) ? '0 : pix_cnt_r + CNT_W'(1);
          end
          default: begin
            byte_idx_r <= 2'd0;
          end
        endcase
      end else begin
        byte_idx_r <= byte_idx_r;
      end
    end
  end

  // Output pixel register and status pulses; a new load takes priority over an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_r  <= 1'b0;
      pix_sof_r    <= 1'b0;
      pix_rgb_r    <= '0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      err_count_r  <= 8'h00;
    end else begin
      if (load_s) begin
        pix_valid_r <= 1'b1;
        pix_sof_r   <= sof_pend_r;
        pix_rgb_r   <= {chan_s, g_field_r, r_field_r};
      end else if (pix_valid_r && pix_ready) begin
        pix_valid_r <= 1'b0;
        pix_sof_r   <= 1'b0;
      end else begin
        pix_valid_r <= pix_valid_r;
      end
      frame_done_r <= done_evt_s;
      frame_err_r  <= err_evt_s;
      if (err_evt_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_framer.sv
// Randomised self-checking bench for uart_pixel_framer (2x2 panel, 4-bit colour, timeout 100).
// Pixel and frame-event expectations come from a frame-level model built as each frame is generated.
module tb_uart_pixel_framer;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int CD   = 4;
  localparam int TMO  = 100;
  localparam int NPIX = ROWS * COLS;
`ifdef UART_PIXEL_FRAMER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    rx_data = 8'h00;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          pix_sof;
  logic [3*CD-1:0] pix_rgb;
  logic          frame_done;
  logic          frame_err;
  logic [7:0]    err_count;

  uart_pixel_framer #(
    .PANEL_ROWS(ROWS), .PANEL_COLS(COLS), .COLOR_DEPTH(CD),
    .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          model_err = 0;
  bit          rand_rdy = 1'b0;
  logic [11:0] exp_pix[$];
  logic        exp_sof[$];
  int          exp_evt[$];
  logic [7:0]  pay[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: delivered pixels and frame pulses against the model queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        if (exp_pix.size() == 0) chk("pix_unexpected", 32'(pix_valid), 32'd0);
        else begin
          chk("pix_rgb", 32'(pix_rgb), 32'(exp_pix.pop_front()));
          chk("pix_sof", 32'(pix_sof), 32'(exp_sof.pop_front()));
        end
      end
      if (frame_done) begin
        if (exp_evt.size() == 0) chk("done_unexpected", 32'(frame_done), 32'd0);
        else chk("evt_done", 32'd1, 32'(exp_evt.pop_front()));
      end
      if (frame_err) begin
        if (exp_evt.size() == 0) chk("err_unexpected", 32'(frame_err), 32'd0);
        else chk("evt_err", 32'd2, 32'(exp_evt.pop_front()));
        model_err = (model_err < 255) ? model_err + 1 : 255;
        chk("err_count", 32'(err_count), 32'(model_err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) pix_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int w = 0; w < 2000; w++) begin
      @(negedge clk);
      if (rx_ready) begin
        step();
        rx_valid = 1'b0;
        return;
      end
      step();
      if (w > 50) pix_ready = 1'b1;
    end
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_non_sof();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'hA5) v = 8'h5A;
    return v;
  endfunction

  task automatic fill_pay();
    pay.delete();
    for (int i = 0; i < 3 * NPIX; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame-level model: pixel i is {B,G,R} upper nibbles of payload bytes 3i..3i+2
  task automatic push_expect(input bit bad_ck);
    for (int i = 0; i < NPIX; i++) begin
      exp_pix.push_back({pay[3*i+2][7:4], pay[3*i+1][7:4], pay[3*i][7:4]});
      exp_sof.push_back(i == 0);
    end
    exp_evt.push_back((CK_EN && bad_ck) ? 2 : 1);
  endtask

  task automatic send_rest(input int from, input bit bad_ck, input bit gaps);
    logic [7:0] x;
    x = 8'h00;
    foreach (pay[i]) x ^= pay[i];
    for (int i = from; i < 3 * NPIX; i++) begin
      send_byte(pay[i]);
      if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 50));
    end
    if (CK_EN) send_byte(bad_ck ? (x ^ 8'h01) : x);
  endtask

  task automatic play_frame(input bit bad_ck, input bit gaps);
    push_expect(bad_ck);
    send_byte(8'hA5);
    send_rest(0, bad_ck, gaps);
  endtask

  initial begin
    int n;
    int bad_rdy;
    int bad_rgb;
    int bad_err;
    logic [11:0] rgb0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_pulses", 32'({frame_done, frame_err, pix_sof}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Leading junk ignored, then a known first pixel F0,80,10 -> 18F
    send_byte(8'h00);
    fill_pay();
    pay[0] = 8'hF0; pay[1] = 8'h80; pay[2] = 8'h10;
    play_frame(1'b0, 1'b0);
    idle(3);

    // Checksum good then bad (both complete as good without the checksum build)
    fill_pay();
    play_frame(1'b0, 1'b0);
    fill_pay();
    play_frame(1'b1, 1'b0);
    idle(3);
    chk("err_count_ck", 32'(err_count), 32'(CK_EN ? 1 : 0));

    // Timeout with a partial pixel: error exactly TMO idle cycles after the last byte
    send_byte(8'hA5);
    send_byte(8'hF0);
    send_byte(8'h80);
    exp_evt.push_back(2);
    n = 0;
    while (n < 3 * TMO) begin
      @(negedge clk);
      if (frame_err) break;
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TMO));
    chk("timeout_no_pix", 32'(pix_valid), 32'd0);
    step();
    fill_pay();
    play_frame(1'b0, 1'b0);
    idle(3);

    // Downstream stall with a byte offered: no acceptance, no timeout, stable pixel
    fill_pay();
    push_expect(1'b0);
    pix_ready = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(pay[i]);
    rx_valid = 1'b1;
    rx_data  = pay[3];
    @(negedge clk);
    rgb0 = pix_rgb;
    bad_rdy = 0; bad_rgb = 0; bad_err = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) bad_rdy++;
      if (pix_rgb !== rgb0 || pix_valid !== 1'b1) bad_rgb++;
      if (frame_err !== 1'b0) bad_err++;
    end
    chk("stall_rx_ready", 32'(bad_rdy), 32'd0);
    chk("stall_rgb_stable", 32'(bad_rgb), 32'd0);
    chk("stall_no_timeout", 32'(bad_err), 32'd0);
    step();
    pix_ready = 1'b1;
    send_rest(3, 1'b0, 1'b0);
    idle(3);

    // SOF value inside the payload is plain data
    fill_pay();
    pay[1] = 8'hA5;
    play_frame(1'b0, 1'b0);
    idle(3);

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    rst_n = 1'b0;
    model_err = 0;
    @(negedge clk);
    chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    step();
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) send_byte(rand_non_sof());
    fill_pay();
    play_frame(1'b0, 1'b0);
    idle(3);

    // Random frames: junk, backpressure, in-frame gaps, checksum faults
    rand_rdy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      int junk;
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) send_byte(rand_non_sof());
      fill_pay();
      play_frame(1'($urandom_range(0, 1)), 1'b1);
    end
    rand_rdy = 1'b0;
    pix_ready = 1'b1;
    idle(20);
    chk("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
    chk("evt_queue_empty", 32'(exp_evt.size()), 32'd0);
    chk("final_err_count", 32'(err_count), 32'(model_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
